// File: rtl/vlex_pkg.sv
// Shared definitions for the Verilog character lexer: token kinds, FSM states
// and the two-character operator codes handed to the parser.
package vlex_pkg;

   localparam logic [2:0] TK_IDENT  = 3'd1;
   localparam logic [2:0] TK_NUMBER = 3'd2;
   localparam logic [2:0] TK_OP     = 3'd3;
   localparam logic [2:0] TK_EOF    = 3'd4;
   localparam logic [2:0] TK_ERROR  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_IDENT   = 3'd1,
      ST_NUM     = 3'd2,
      ST_OP      = 3'd3,
      ST_COMMENT = 3'd4
   } state_t;

   localparam int unsigned HASH_MUL = 31;

   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_UNDER = 8'h5F;

   // Operator codes are {second char, first char}
   localparam logic [15:0] OPC_SHL  = 16'h3C3C;
   localparam logic [15:0] OPC_SHR  = 16'h3E3E;
   localparam logic [15:0] OPC_LE   = 16'h3D3C;
   localparam logic [15:0] OPC_GE   = 16'h3D3E;
   localparam logic [15:0] OPC_EQ   = 16'h3D3D;
   localparam logic [15:0] OPC_NE   = 16'h3D21;
   localparam logic [15:0] OPC_LAND = 16'h2626;
   localparam logic [15:0] OPC_LOR  = 16'h7C7C;
   localparam logic [15:0] OPC_INC  = 16'h2B2B;
   localparam logic [15:0] OPC_DEC  = 16'h2D2D;
   localparam logic [15:0] OPC_POW  = 16'h2A2A;

endpackage

// File: rtl/vlex_char_class.sv
// Combinational character classifier; also recognises two-character operators
// formed by a held first character and the current character.
module vlex_char_class
   import vlex_pkg::*;
(
   input  logic [7:0] char_i,
   input  logic [7:0] c0_i,
   output logic       is_space_o,
   output logic       is_ident_start_o,
   output logic       is_ident_o,
   output logic       is_digit_o,
   output logic       is_punct_o,
   output logic       is_eos_o,
   output logic       is_bad_o,
   output logic       pair_ok_o
);

   logic alpha;

   always_comb begin
      alpha            = (char_i >= 8'h41 && char_i <= 8'h5A) || (char_i >= 8'h61 && char_i <= 8'h7A);
      is_digit_o       = (char_i >= 8'h30 && char_i <= 8'h39);
      is_ident_start_o = alpha || (char_i == CH_UNDER) || (char_i == 8'h24);
      is_ident_o       = is_ident_start_o || is_digit_o;
      is_space_o       = (char_i == 8'h20) || (char_i == 8'h09) || (char_i == 8'h0D) || (char_i == CH_LF);
      is_eos_o         = (char_i == 8'h00);
      is_punct_o       = (char_i >= 8'h21) && (char_i <= 8'h7E) && !is_ident_o;
      is_bad_o         = !is_eos_o && !is_space_o && ((char_i < 8'h20) || (char_i > 8'h7E));

      case ({char_i, c0_i})
         OPC_SHL, OPC_SHR, OPC_LE, OPC_GE, OPC_EQ, OPC_NE,
         OPC_LAND, OPC_LOR, OPC_INC, OPC_DEC, OPC_POW: pair_ok_o = 1'b1;
         default:                                      pair_ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/vlog_char_lexer.sv
// Byte-stream tokenizer feeding the Verilog parser: one classified token per
// output handshake, registered output, whole lexer stalls while the token slot is full.
module vlog_char_lexer
   import vlex_pkg::*;
#(
   parameter int VAL_W  = 32,
   parameter int LEN_W  = 6,
   parameter int LINE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_char,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic [2:0]        tok_kind,
   output logic [VAL_W-1:0]  tok_value,
   output logic [LEN_W-1:0]  tok_len,
   output logic [LINE_W-1:0] tok_line
);

   state_t              state_q, state_d;
   logic [VAL_W-1:0]    acc_q, acc_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [7:0]          c0_q, c0_d;
   logic [LINE_W-1:0]   tline_q, tline_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                tvld_q, tvld_d;
   logic [2:0]          tkind_q;
   logic [VAL_W-1:0]    tval_q;
   logic [LEN_W-1:0]    tlen_q;
   logic [LINE_W-1:0]   tln_q;

   logic                is_space, is_ident_start, is_ident, is_digit;
   logic                is_punct, is_eos, is_bad, pair_ok;
   logic                free, go, consume, emit;
   logic [2:0]          e_kind;
   logic [VAL_W-1:0]    e_val;
   logic [LEN_W-1:0]    e_len;
   logic [LINE_W-1:0]   e_line;
   logic [3:0]          digit;
   logic [VAL_W+3:0]    prod;

   vlex_char_class u_class (
      .char_i           (in_char),
      .c0_i             (c0_q),
      .is_space_o       (is_space),
      .is_ident_start_o (is_ident_start),
      .is_ident_o       (is_ident),
      .is_digit_o       (is_digit),
      .is_punct_o       (is_punct),
      .is_eos_o         (is_eos),
      .is_bad_o         (is_bad),
      .pair_ok_o        (pair_ok)
   );

   function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
      return (&l) ? l : l + LEN_W'(1);
   endfunction

   assign free     = !tvld_q || tok_ready;
   assign go       = in_valid && free;
   assign in_ready = rst_n && free && consume;
   assign digit    = in_char[3:0];

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      len_d   = len_q;
      c0_d    = c0_q;
      tline_d = tline_q;
      consume = 1'b0;
      emit    = 1'b0;
      e_kind  = TK_EOF;
      e_val   = '0;
      e_len   = '0;
      e_line  = line_q;
      prod    = ({4'd0, acc_q} * (VAL_W+4)'(10)) + (VAL_W+4)'(digit);

      case (state_q)
         ST_IDLE: begin
            consume = is_space || is_ident_start || is_digit || is_punct || is_eos || is_bad;
            if (is_ident_start) begin
               state_d = ST_IDENT;
               acc_d   = VAL_W'(in_char);
               len_d   = LEN_W'(1);
               tline_d = line_q;
            end else if (is_digit) begin
               state_d = ST_NUM;
               acc_d   = VAL_W'(digit);
               len_d   = LEN_W'(1);
               tline_d = line_q;
            end else if (is_punct) begin
               state_d = ST_OP;
               c0_d    = in_char;
               tline_d = line_q;
            end else if (is_eos) begin
               emit    = 1'b1;
            end else if (!is_space) begin
               emit    = 1'b1;
               e_kind  = TK_ERROR;
               e_val   = VAL_W'(in_char);
               e_len   = LEN_W'(1);
            end
         end
         ST_IDENT: begin
            if (is_ident) begin
               consume = 1'b1;
               acc_d   = acc_q * VAL_W'(HASH_MUL) + VAL_W'(in_char);
               len_d   = len_inc(len_q);
            end else begin
               emit    = 1'b1;
               e_kind  = TK_IDENT;
               e_val   = acc_q;
               e_len   = len_q;
               e_line  = tline_q;
               state_d = ST_IDLE;
            end
         end
         ST_NUM: begin
            if (is_digit || in_char == CH_UNDER) begin
               consume = 1'b1;
               len_d   = len_inc(len_q);
               // Overflow pins the value at all-ones; any further digit overflows again
               if (is_digit)
                  acc_d = (prod[VAL_W+3:VAL_W] != 4'd0) ? '1 : prod[VAL_W-1:0];
            end else begin
               emit    = 1'b1;
               e_kind  = TK_NUMBER;
               e_val   = acc_q;
               e_len   = len_q;
               e_line  = tline_q;
               state_d = ST_IDLE;
            end
         end
         ST_OP: begin
            e_kind  = TK_OP;
            e_line  = tline_q;
            state_d = ST_IDLE;
            if (c0_q == CH_SLASH && in_char == CH_SLASH) begin
               consume = 1'b1;
               state_d = ST_COMMENT;
            end else if (pair_ok) begin
               consume = 1'b1;
               emit    = 1'b1;
               e_val   = VAL_W'({in_char, c0_q});
               e_len   = LEN_W'(2);
            end else begin
               emit    = 1'b1;
               e_val   = VAL_W'(c0_q);
               e_len   = LEN_W'(1);
            end
         end
         ST_COMMENT: begin
            if (in_char == CH_LF || is_eos) state_d = ST_IDLE;
            else                            consume = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      line_d = (consume && in_char == CH_LF) ? line_q + LINE_W'(1) : line_q;
      tvld_d = (go && emit) ? 1'b1 : (tok_ready ? 1'b0 : tvld_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         len_q   <= '0;
         c0_q    <= '0;
         tline_q <= '0;
         line_q  <= LINE_W'(1);
         tvld_q  <= 1'b0;
         tkind_q <= '0;
         tval_q  <= '0;
         tlen_q  <= '0;
         tln_q   <= '0;
      end else begin
         tvld_q <= tvld_d;
         if (go) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            c0_q    <= c0_d;
            tline_q <= tline_d;
            line_q  <= line_d;
            if (emit) begin
               tkind_q <= e_kind;
               tval_q  <= e_val;
               tlen_q  <= e_len;
               tln_q   <= e_line;
            end
         end
      end
   end

   assign tok_valid = tvld_q;
   assign tok_kind  = tkind_q;
   assign tok_value = tval_q;
   assign tok_len   = tlen_q;
   assign tok_line  = tln_q;

endmodule

// File: tb/tb_vlog_char_lexer.sv
// Bench for vlog_char_lexer: a whole-string reference lexer predicts the token
// sequence; a monitor compares every accepted token against it.
module tb_vlog_char_lexer;

   typedef struct {
      logic [2:0]  k;
      logic [31:0] v;
      logic [5:0]  l;
      logic [15:0] ln;
   } tok_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_char = 8'h00;
   logic        tok_valid;
   logic        tok_ready = 1'b1;
   logic [2:0]  tok_kind;
   logic [31:0] tok_value;
   logic [5:0]  tok_len;
   logic [15:0] tok_line;

   int   checks = 0;
   int   failures = 0;
   int   block_cnt = 0;
   bit   rdy_rand = 1'b0;
   tok_t exp_q[$];
   logic [15:0] m_line = 16'd1;

   vlog_char_lexer #(.VAL_W(32), .LEN_W(6), .LINE_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_char   (in_char),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .tok_kind  (tok_kind),
      .tok_value (tok_value),
      .tok_len   (tok_len),
      .tok_line  (tok_line)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endfunction

   // ---------------- reference lexer ----------------
   function automatic bit is_dig(byte unsigned c);
      return c >= 8'h30 && c <= 8'h39;
   endfunction
   function automatic bit id_start(byte unsigned c);
      return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || c == 8'h5F || c == 8'h24;
   endfunction
   function automatic bit is_pair(byte unsigned a, byte unsigned b);
      string pl = "<<>><=>===!=&&||++--**";
      for (int j = 0; j < pl.len(); j += 2)
         if (pl[j] == a && pl[j+1] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_run(input byte unsigned s[$], output tok_t r[$]);
      int i = 0;
      int n = s.size();
      r = {};
      while (i < n) begin
         byte unsigned c;
         tok_t t;
         c = s[i];
         t.ln = m_line;
         if (c == 8'h00) begin
            t.k = 3'd4; t.v = 0; t.l = 0; r.push_back(t); i++;
         end else if (c == 8'd9 || c == 8'd10 || c == 8'd13 || c == 8'd32) begin
            if (c == 8'd10) m_line++;
            i++;
         end else if (id_start(c)) begin
            logic [31:0] h;
            int len;
            h = 32'(c); len = 1; i++;
            while (i < n && (id_start(s[i]) || is_dig(s[i]))) begin
               h = h * 32'd31 + 32'(s[i]); len++; i++;
            end
            t.k = 3'd1; t.v = h; t.l = (len > 63) ? 6'd63 : 6'(len); r.push_back(t);
         end else if (is_dig(c)) begin
            longint v;
            bit sat;
            int len;
            v = longint'(c) - 48; sat = 1'b0; len = 1; i++;
            while (i < n && (is_dig(s[i]) || s[i] == 8'h5F)) begin
               if (s[i] != 8'h5F && !sat) begin
                  v = v * 10 + (longint'(s[i]) - 48);
                  if (v > 64'hFFFF_FFFF) sat = 1'b1;
               end
               len++; i++;
            end
            t.k = 3'd2; t.v = sat ? 32'hFFFF_FFFF : v[31:0]; t.l = (len > 63) ? 6'd63 : 6'(len); r.push_back(t);
         end else if (c >= 8'h21 && c <= 8'h7E) begin
            if (i + 1 < n && c == 8'h2F && s[i+1] == 8'h2F) begin
               i += 2;
               while (i < n && s[i] != 8'd10 && s[i] != 8'h00) i++;
            end else if (i + 1 < n && is_pair(c, s[i+1])) begin
               t.k = 3'd3; t.v = {16'h0, s[i+1], c}; t.l = 6'd2; r.push_back(t); i += 2;
            end else begin
               t.k = 3'd3; t.v = 32'(c); t.l = 6'd1; r.push_back(t); i++;
            end
         end else begin
            t.k = 3'd5; t.v = 32'(c); t.l = 6'd1; r.push_back(t); i++;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic mkq(input string s, output byte unsigned q[$]);
      q = {};
      for (int j = 0; j < s.len(); j++) q.push_back(s[j]);
      q.push_back(8'h00);
   endtask

   task automatic drive(input byte unsigned q[$]);
      foreach (q[k]) begin
         int tries = 0;
         bit done = 1'b0;
         while (!done) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 4) != 0);
            in_char  = in_valid ? q[k] : 8'($urandom);
            #4;
            if (in_valid && in_ready) done = 1'b1;
            else if (++tries > 300) begin
               checks++; failures++;
               $display("FAIL drive_timeout: byte %0d in_ready=%0b, expected 1 within 300 cycles", k, in_ready);
               done = 1'b1;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input byte unsigned q[$], output tok_t r[$]);
      model_run(q, r);
      foreach (r[j]) exp_q.push_back(r[j]);
      drive(q);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk); t++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic pin(string nm, tok_t t, logic [2:0] k, logic [31:0] v, logic [5:0] l, logic [15:0] ln);
      chk({nm, "_kind"}, 64'(t.k), 64'(k));
      chk({nm, "_value"}, 64'(t.v), 64'(v));
      chk({nm, "_len"}, 64'(t.l), 64'(l));
      chk({nm, "_line"}, 64'(t.ln), 64'(ln));
   endtask

   task automatic gen(output byte unsigned q[$]);
      string ops = "<>=!&|+-*/;(),";
      int n = $urandom_range(10, 40);
      q = {};
      for (int j = 0; j < n; j++) begin
         int r = $urandom_range(0, 99);
         if      (r < 28) q.push_back(8'h61 + 8'($urandom_range(0, 25)));
         else if (r < 48) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
         else if (r < 62) q.push_back(ops[$urandom_range(0, ops.len() - 1)]);
         else if (r < 72) q.push_back(8'h20);
         else if (r < 78) q.push_back(8'h0A);
         else if (r < 82) q.push_back(8'h5F);
         else if (r < 84) q.push_back(8'h24);
         else if (r < 86) q.push_back(8'h09);
         else if (r < 88) q.push_back(8'h80 | 8'($urandom_range(0, 127)));
         else if (r < 89) q.push_back(8'h07);
         else if (r < 91) q.push_back(8'h00);
         else             q.push_back(8'h2F);
      end
      q.push_back(8'h00);
   endtask

   // ---------------- token-ready driver ----------------
   initial forever begin
      @(negedge clk);
      if (block_cnt > 0) begin
         tok_ready = 1'b0;
         block_cnt--;
      end else begin
         tok_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // ---------------- compare process ----------------
   initial forever begin
      tok_t e;
      @(negedge clk);
      #4;
      if (!rst_n) begin
         chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      end else begin
         if (tok_valid && !tok_ready) chk("in_ready_blocked", 64'(in_ready), 64'd0);
         if (tok_valid && tok_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_token: got kind=%0d value=0x%0h, expected no token", tok_kind, tok_value);
            end else begin
               e = exp_q.pop_front();
               chk("tok_kind", 64'(tok_kind), 64'(e.k));
               chk("tok_value", 64'(tok_value), 64'(e.v));
               chk("tok_len", 64'(tok_len), 64'(e.l));
               chk("tok_line", 64'(tok_line), 64'(e.ln));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      byte unsigned q[$];
      tok_t r[$];
      string s;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #4;
      chk("rst_tok_valid", 64'(tok_valid), 64'd0);
      chk("rst_tok_kind", 64'(tok_kind), 64'd0);
      chk("rst_tok_value", 64'(tok_value), 64'd0);
      chk("rst_tok_len", 64'(tok_len), 64'd0);
      chk("rst_tok_line", 64'(tok_line), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      mkq("x = y;\n", q);
      send(q, r);
      chk("t1_count", 64'(r.size()), 64'd5);
      if (r.size() == 5) begin
         pin("t1_x", r[0], 3'd1, 32'h78, 6'd1, 16'd1);
         pin("t1_eq", r[1], 3'd3, 32'h3D, 6'd1, 16'd1);
         pin("t1_y", r[2], 3'd1, 32'h79, 6'd1, 16'd1);
         pin("t1_semi", r[3], 3'd3, 32'h3B, 6'd1, 16'd1);
         pin("t1_eof", r[4], 3'd4, 32'h0, 6'd0, 16'd2);
      end
      drain();

      mkq("1_000<<<2", q);
      send(q, r);
      chk("t2_count", 64'(r.size()), 64'd5);
      if (r.size() == 5) begin
         pin("t2_num", r[0], 3'd2, 32'd1000, 6'd5, 16'd2);
         pin("t2_shl", r[1], 3'd3, 32'h3C3C, 6'd2, 16'd2);
         pin("t2_lt", r[2], 3'd3, 32'h3C, 6'd1, 16'd2);
         pin("t2_two", r[3], 3'd2, 32'd2, 6'd1, 16'd2);
      end
      drain();

      mkq("a//c\nb", q);
      send(q, r);
      chk("t3_count", 64'(r.size()), 64'd3);
      if (r.size() == 3) begin
         pin("t3_a", r[0], 3'd1, 32'h61, 6'd1, 16'd2);
         pin("t3_b", r[1], 3'd1, 32'h62, 6'd1, 16'd3);
         pin("t3_eof", r[2], 3'd4, 32'h0, 6'd0, 16'd3);
      end
      drain();

      mkq("99999999999", q);
      send(q, r);
      pin("t4_sat", r[0], 3'd2, 32'hFFFF_FFFF, 6'd11, 16'd3);
      drain();

      q = {8'h07, 8'h00};
      send(q, r);
      pin("t5_err", r[0], 3'd5, 32'h7, 6'd1, 16'd3);
      drain();

      s = "";
      for (int j = 0; j < 70; j++) s = {s, "a"};
      mkq(s, q);
      send(q, r);
      chk("t6_len_sat", 64'(r[0].l), 64'd63);
      drain();

      mkq("ab+cd", q);
      fork
         send(q, r);
         begin
            repeat (3) @(negedge clk);
            block_cnt = 5;
         end
      join
      chk("t7_count", 64'(r.size()), 64'd4);
      if (r.size() == 4) begin
         pin("t7_ab", r[0], 3'd1, 32'h61 * 31 + 32'h62, 6'd2, 16'd3);
         pin("t7_plus", r[1], 3'd3, 32'h2B, 6'd1, 16'd3);
         pin("t7_cd", r[2], 3'd1, 32'h63 * 31 + 32'h64, 6'd2, 16'd3);
      end
      drain();

      rdy_rand = 1'b1;
      for (int n = 0; n < 30; n++) begin
         gen(q);
         send(q, r);
      end
      drain();

      rdy_rand = 1'b0;
      q = {8'h61, 8'h62};
      drive(q);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_line = 16'd1;
      #4;
      chk("t8_post_rst_valid", 64'(tok_valid), 64'd0);
      mkq("zz", q);
      send(q, r);
      pin("t8_zz", r[0], 3'd1, 32'h7A * 31 + 32'h7A, 6'd2, 16'd1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
